uart_tx_sched: RTL and testbench

- Two-requester scheduler that shares the single UART TX frame engine (serializer, parity, FSM path).
- Arbitrates round-robin between a byte requester (REQ0, e.g. register-file read data) and a word requester (REQ1, e.g. 16-bit ALU result sent as two frames, low byte first).
- Drives the TX engine's P_DATA, DATA_VALID, PAR_EN and PAR_TYP, and paces frames from the engine's Busy output.
- Retries a frame the engine never accepts, and drops it after a bounded number of retries.

---
 rtl/uart_tx_sched.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART TX frame engine between a byte source
// (REQ0) and a 16-bit word source (REQ1), with accept-timeout retry and drop.
module uart_tx_sched #(
  parameter int DATA_WIDTH     = 8,
  parameter int ACCEPT_TIMEOUT = 15,
  parameter int MAX_RETRY      = 3
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ0,
  input  logic [DATA_WIDTH-1:0]   REQ0_DATA,
  input  logic                    REQ1,
  input  logic [2*DATA_WIDTH-1:0] REQ1_DATA,
  input  logic                    CFG_PAR_EN,
  input  logic                    CFG_PAR_TYP,
  input  logic                    TX_BUSY,
  output logic                    ACK0,
  output logic                    ACK1,
  output logic                    ERR,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_DATA_VALID,
  output logic                    TX_PAR_EN,
  output logic                    TX_PAR_TYP,
  output logic                    SCHED_BUSY
);

  localparam int TIMER_W = $clog2(ACCEPT_TIMEOUT + 1);
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;

  state_t                  state_q, state_d;
  logic                    rr_q, rr_d;
  logic                    owner_q, owner_d;
  logic                    idx_q, idx_d;
  logic [2*DATA_WIDTH-1:0] data_q, data_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic [RETRY_W-1:0]      retry_q, retry_d;
  logic                    grant;
  logic                    pe_d, pt_d, dv_d, ack0_d, ack1_d, err_d;
  logic [DATA_WIDTH-1:0]   p_data_d;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    idx_d   = idx_q;
    data_d  = data_q;
    timer_d = timer_q;
    retry_d = retry_q;
    pe_d    = TX_PAR_EN;
    pt_d    = TX_PAR_TYP;
    grant   = 1'b0;
    dv_d    = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (REQ0 || REQ1) begin
          grant   = (REQ0 && REQ1) ? !rr_q : REQ1;
          rr_d    = grant;
          owner_d = grant;
          data_d  = grant ? REQ1_DATA : {{DATA_WIDTH{1'b0}}, REQ0_DATA};
          pe_d    = CFG_PAR_EN;
          pt_d    = CFG_PAR_TYP;
          idx_d   = 1'b0;
          retry_d = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!TX_BUSY) begin
          dv_d    = 1'b1;
          timer_d = '0;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (TX_BUSY) begin
          retry_d = '0;
          state_d = WAIT_LO;
        end else if (timer_q == TIMER_W'(ACCEPT_TIMEOUT - 1)) begin
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = LOAD;
          end else begin
            ack0_d  = !owner_q;
            ack1_d  = owner_q;
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      WAIT_LO: begin
        if (!TX_BUSY) begin
          if (owner_q && !idx_q) begin
            // Engine is known idle right now, so the high byte is pulsed
            // directly: DATA_VALID follows the Busy fall by one cycle.
            idx_d   = 1'b1;
            dv_d    = 1'b1;
            timer_d = '0;
            state_d = WAIT_HI;
          end else begin
            ack0_d  = !owner_q;
            ack1_d  = owner_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    p_data_d = idx_d ? data_d[2*DATA_WIDTH-1:DATA_WIDTH] : data_d[DATA_WIDTH-1:0];
  end

  // NOTE: state and outputs update with non-blocking assignments so every
  // register samples the values from before this edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      // NOTE: the payload register is reset too; TX_P_DATA is derived from it
      // and must read 0 out of reset.
      state_q       <= IDLE;
      rr_q          <= 1'b0;
      owner_q       <= 1'b0;
      idx_q         <= 1'b0;
      data_q        <= '0;
      timer_q       <= '0;
      retry_q       <= '0;
      TX_P_DATA     <= '0;
      TX_DATA_VALID <= 1'b0;
      TX_PAR_EN     <= 1'b0;
      TX_PAR_TYP    <= 1'b0;
      ACK0          <= 1'b0;
      ACK1          <= 1'b0;
      ERR           <= 1'b0;
      SCHED_BUSY    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      owner_q       <= owner_d;
      idx_q         <= idx_d;
      data_q        <= data_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      TX_P_DATA     <= p_data_d;
      TX_DATA_VALID <= dv_d;
      TX_PAR_EN     <= pe_d;
      TX_PAR_TYP    <= pt_d;
      ACK0          <= ack0_d;
      ACK1          <= ack1_d;
      ERR           <= err_d;
      SCHED_BUSY    <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: directed requests push expected frame and
// ACK events; a monitor pops and compares them as the DUT presents them.
module tb_uart_tx_sched;

  localparam int DW       = 8;
  localparam int TO       = 15;
  localparam int MR       = 3;
  localparam int BUSY_LEN = 11;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ0, REQ1;
  logic [DW-1:0] REQ0_DATA;
  logic [2*DW-1:0] REQ1_DATA;
  logic          CFG_PAR_EN, CFG_PAR_TYP;
  logic          TX_BUSY;
  logic          ACK0, ACK1, ERR;
  logic [DW-1:0] TX_P_DATA;
  logic          TX_DATA_VALID, TX_PAR_EN, TX_PAR_TYP, SCHED_BUSY;

  logic eng_busy, force_busy, eng_deaf;
  assign TX_BUSY = eng_busy | force_busy;

  uart_tx_sched #(.DATA_WIDTH(DW), .ACCEPT_TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .REQ0_DATA(REQ0_DATA),
    .REQ1(REQ1), .REQ1_DATA(REQ1_DATA),
    .CFG_PAR_EN(CFG_PAR_EN), .CFG_PAR_TYP(CFG_PAR_TYP),
    .TX_BUSY(TX_BUSY),
    .ACK0(ACK0), .ACK1(ACK1), .ERR(ERR),
    .TX_P_DATA(TX_P_DATA), .TX_DATA_VALID(TX_DATA_VALID),
    .TX_PAR_EN(TX_PAR_EN), .TX_PAR_TYP(TX_PAR_TYP),
    .SCHED_BUSY(SCHED_BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          is_ack;
    logic [DW-1:0] data;
    logic          pe;
    logic          pt;
    logic          a0;
    logic          a1;
    logic          err;
    int            at;   // absolute cycle, or -1
    int            gap;  // cycles since previous event, or -1
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_ev = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_dv(input logic [DW-1:0] d, input logic pe, input logic pt,
                                  input int at, input int gap);
    sb.push_back('{is_ack: 1'b0, data: d, pe: pe, pt: pt, a0: 1'b0, a1: 1'b0, err: 1'b0,
                   at: at, gap: gap});
  endfunction

  function automatic void push_ack(input logic a0, input logic a1, input logic err, input int gap);
    sb.push_back('{is_ack: 1'b1, data: '0, pe: 1'b0, pt: 1'b0, a0: a0, a1: a1, err: err,
                   at: -1, gap: gap});
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST && (TX_DATA_VALID || ACK0 || ACK1 || ERR)) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {TX_DATA_VALID, ACK0, ACK1, ERR}, 32'h0);
        end else begin
          e = sb.pop_front();
          check("event_kind", {TX_DATA_VALID, ACK0, ACK1, ERR}, {!e.is_ack, e.a0, e.a1, e.err});
          check("sched_busy", SCHED_BUSY, !e.is_ack);
          if (!e.is_ack) check("frame_data", {TX_P_DATA, TX_PAR_EN, TX_PAR_TYP}, {e.data, e.pe, e.pt});
          if (e.at >= 0) check("event_cycle", cyc, e.at);
          if (e.gap >= 0) check("event_gap", cyc - last_ev, e.gap);
        end
        last_ev = cyc;
      end
    end
  end

  // Engine model: Busy from the DATA_VALID cycle for BUSY_LEN cycles
  initial begin
    eng_busy = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST && TX_DATA_VALID && !eng_deaf) begin
        eng_busy = 1'b1;
        repeat (BUSY_LEN) @(negedge CLK);
        eng_busy = 1'b0;
      end
    end
  end

  task automatic do_req(input int idx, input logic [2*DW-1:0] data);
    logic got;
    got = 1'b0;
    if (idx == 0) begin REQ0_DATA = data[DW-1:0]; REQ0 = 1'b1; end
    else          begin REQ1_DATA = data;         REQ1 = 1'b1; end
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if ((idx == 0) ? ACK0 : ACK1) begin got = 1'b1; break; end
    end
    if (idx == 0) REQ0 = 1'b0; else REQ1 = 1'b0;
    check($sformatf("ack%0d_seen", idx), got, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge CLK);
    check("scoreboard_drained", sb.size(), 0);
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; REQ0_DATA = '0; REQ1_DATA = '0;
    CFG_PAR_EN = 1'b0; CFG_PAR_TYP = 1'b0; force_busy = 1'b0; eng_deaf = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_p_data", TX_P_DATA, 0);
    check("rst_tx_ctrl", {TX_DATA_VALID, TX_PAR_EN, TX_PAR_TYP}, 0);
    check("rst_ack_err", {ACK0, ACK1, ERR}, 0);
    check("rst_sched_busy", SCHED_BUSY, 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("idle_no_req", {SCHED_BUSY, TX_DATA_VALID}, 0);

    // Single byte; CFG changed after grant must not affect the frame
    CFG_PAR_EN = 1'b1; CFG_PAR_TYP = 1'b0;
    push_dv(8'hA5, 1'b1, 1'b0, cyc + 2, -1);
    push_ack(1'b1, 1'b0, 1'b0, BUSY_LEN + 1);
    fork
      do_req(0, 16'h00A5);
      begin @(negedge CLK); CFG_PAR_EN = 1'b0; CFG_PAR_TYP = 1'b1; end
    join
    drain();

    // Single word: low byte, then high byte one cycle after Busy falls
    CFG_PAR_EN = 1'b1; CFG_PAR_TYP = 1'b1;
    push_dv(8'h34, 1'b1, 1'b1, cyc + 2, -1);
    push_dv(8'h12, 1'b1, 1'b1, -1, BUSY_LEN + 1);
    push_ack(1'b0, 1'b1, 1'b0, BUSY_LEN + 1);
    do_req(1, 16'h1234);
    drain();

    // Both together after a REQ1 grant: REQ0 wins
    CFG_PAR_EN = 1'b0; CFG_PAR_TYP = 1'b0;
    push_dv(8'h77, 1'b0, 1'b0, cyc + 2, -1);
    push_ack(1'b1, 1'b0, 1'b0, BUSY_LEN + 1);
    push_dv(8'h88, 1'b0, 1'b0, -1, 2);
    push_dv(8'h99, 1'b0, 1'b0, -1, BUSY_LEN + 1);
    push_ack(1'b0, 1'b1, 1'b0, BUSY_LEN + 1);
    fork
      do_req(0, 16'h0077);
      do_req(1, 16'h9988);
    join
    drain();

    // Fairness from reset: order 1,0,1,0 with immediate re-requests
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    push_dv(8'hEF, 1'b0, 1'b0, cyc + 2, -1);
    push_dv(8'hBE, 1'b0, 1'b0, -1, BUSY_LEN + 1);
    push_ack(1'b0, 1'b1, 1'b0, BUSY_LEN + 1);
    push_dv(8'h11, 1'b0, 1'b0, -1, 2);
    push_ack(1'b1, 1'b0, 1'b0, BUSY_LEN + 1);
    push_dv(8'hFE, 1'b0, 1'b0, -1, 2);
    push_dv(8'hCA, 1'b0, 1'b0, -1, BUSY_LEN + 1);
    push_ack(1'b0, 1'b1, 1'b0, BUSY_LEN + 1);
    push_dv(8'h22, 1'b0, 1'b0, -1, 2);
    push_ack(1'b1, 1'b0, 1'b0, BUSY_LEN + 1);
    fork
      begin do_req(0, 16'h0011); do_req(0, 16'h0022); end
      begin do_req(1, 16'hBEEF); do_req(1, 16'hCAFE); end
    join
    drain();

    // Engine never accepts: 4 pulses TO+1 apart, then ACK0 with ERR
    eng_deaf = 1'b1;
    CFG_PAR_EN = 1'b1; CFG_PAR_TYP = 1'b1;
    push_dv(8'h5A, 1'b1, 1'b1, cyc + 2, -1);
    for (int i = 0; i < MR; i++) push_dv(8'h5A, 1'b1, 1'b1, -1, TO + 1);
    push_ack(1'b1, 1'b0, 1'b1, TO);
    do_req(0, 16'h005A);
    drain();
    eng_deaf = 1'b0;

    // Engine already busy in LOAD: DATA_VALID held off until Busy falls
    force_busy = 1'b1;
    CFG_PAR_EN = 1'b0; CFG_PAR_TYP = 1'b1;
    push_dv(8'h3C, 1'b0, 1'b1, cyc + 7, -1);
    push_ack(1'b1, 1'b0, 1'b0, BUSY_LEN + 1);
    fork
      do_req(0, 16'h003C);
      begin
        repeat (6) @(negedge CLK);
        check("load_hold", {SCHED_BUSY, TX_DATA_VALID}, 2'b10);
        force_busy = 1'b0;
      end
    join
    drain();

    // Reset during WAIT_LO of the first REQ1 byte
    CFG_PAR_EN = 1'b1; CFG_PAR_TYP = 1'b0;
    push_dv(8'hB2, 1'b1, 1'b0, cyc + 2, -1);
    REQ1_DATA = 16'hA1B2; REQ1 = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge CLK);
    check("first_byte_sent", sb.size(), 0);
    repeat (3) @(negedge CLK);
    check("wait_lo_hold", {SCHED_BUSY, TX_P_DATA}, {1'b1, 8'hB2});
    RST = 1'b0;
    #1;
    check("abort_data", TX_P_DATA, 0);
    check("abort_ctrl", {TX_DATA_VALID, TX_PAR_EN, TX_PAR_TYP, ACK0, ACK1, ERR, SCHED_BUSY}, 0);
    repeat (15) @(negedge CLK);
    push_dv(8'hB2, 1'b1, 1'b0, cyc + 2, -1);
    push_dv(8'hA1, 1'b1, 1'b0, -1, BUSY_LEN + 1);
    push_ack(1'b0, 1'b1, 1'b0, BUSY_LEN + 1);
    RST = 1'b1;
    do_req(1, 16'hA1B2);
    drain();

    check("final_idle", {SCHED_BUSY, ACK0, ACK1, ERR}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
